// File: rtl/crt_parser.sv
// crt_parser: streaming .CRT cartridge image parser.
// Extracts the header (hardware type, EXROM, GAME) and each CHIP packet descriptor, packs every
// bank's payload into SDRAM on an 8K boundary and drives the cartridge mapper's bank interface.
// Optional feature macro CRT_BIN_EN: accept raw .bin images (first byte not 'C').
module crt_parser #(
    parameter logic [24:0] RAM_BASE  = 25'h0100000,
    parameter int unsigned MAX_UNITS = 128
) (
    input  logic        clk32,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [7:0]  dl_data,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_wr,
    output logic [15:0] cart_id,
    output logic [7:0]  cart_exrom,
    output logic [7:0]  cart_game,
    output logic [15:0] cart_bank_laddr,
    output logic [15:0] cart_bank_size,
    output logic [15:0] cart_bank_num,
    output logic [7:0]  cart_bank_type,
    output logic [24:0] cart_bank_raddr,
    output logic        cart_bank_wr,
    output logic        cart_loading,
    output logic        cart_attached,
    output logic        crt_error
);

    typedef enum logic [2:0] {StIdle, StSig, StHdr, StChdr, StCdata, StCskip, StErr, StBin} state_t;

    localparam logic [127:0] SigStr  = "C64 CARTRIDGE   ";
    localparam logic [31:0]  ChipStr = "CHIP";

    state_t      state;
    logic [31:0] cnt;       // file offset of the current byte
    logic [31:0] pcnt;      // offset of the current byte within its CHIP packet
    logic [31:0] hdr_len;
    logic [31:0] pkt_len;
    logic [7:0]  unit_ptr;
    logic        any_bank;
    logic        dl_prev;

    logic        dl_rise, dl_fall;
    logic [127:0] sig_word;
    logic [31:0] chip_word;
    logic [31:0] hdr_eff, cnt_nx, pcnt_nx, data_off, data_end;
    logic [15:0] size_now;
    logic [16:0] size_rnd;
    logic [3:0]  units;
    logic [8:0]  unit_sum;
    logic        units_over;

    // Edge detect and per-byte helper arithmetic
    always_comb begin
        dl_rise    = dl_active & ~dl_prev;
        dl_fall    = ~dl_active & dl_prev;
        sig_word   = SigStr << {cnt[3:0], 3'b000};
        chip_word  = ChipStr << {pcnt[1:0], 3'b000};
        hdr_eff    = (hdr_len < 32'd64) ? 32'd64 : hdr_len;
        cnt_nx     = cnt + 32'd1;
        pcnt_nx    = pcnt + 32'd1;
        data_off   = pcnt - 32'd16;
        data_end   = 32'd16 + {16'd0, cart_bank_size};
        size_now   = {cart_bank_size[15:8], dl_data};
        size_rnd   = {1'b0, size_now} + 17'd8191;
        units      = size_rnd[16:13];
        if (units == 4'd0) begin
            units = 4'd1;   // an empty CHIP still claims one 8K unit
        end
        unit_sum   = {1'b0, unit_ptr} + {5'd0, units};
        units_over = unit_sum > 9'(MAX_UNITS);
    end

    // Parser FSM with registered mapper and SDRAM outputs
    always_ff @(posedge clk32) begin
        if (reset) begin
            state           <= StIdle;
            cnt             <= '0;
            pcnt            <= '0;
            hdr_len         <= '0;
            pkt_len         <= '0;
            unit_ptr        <= '0;
            any_bank        <= 1'b0;
            dl_prev         <= 1'b1;   // a download already in flight must not look like a new one
            mem_addr        <= '0;
            mem_data        <= '0;
            mem_wr          <= 1'b0;
            cart_id         <= '0;
            cart_exrom      <= '0;
            cart_game       <= '0;
            cart_bank_laddr <= '0;
            cart_bank_size  <= '0;
            cart_bank_num   <= '0;
            cart_bank_type  <= '0;
            cart_bank_raddr <= '0;
            cart_bank_wr    <= 1'b0;
            cart_loading    <= 1'b0;
            cart_attached   <= 1'b0;
            crt_error       <= 1'b0;
        end else begin
            mem_wr       <= 1'b0;
            cart_bank_wr <= 1'b0;
            cart_loading <= dl_active;
            dl_prev      <= dl_active;
            if (dl_rise) begin
                state         <= StSig;
                cnt           <= '0;
                pcnt          <= '0;
                unit_ptr      <= '0;
                any_bank      <= 1'b0;
                hdr_len       <= '0;
                pkt_len       <= '0;
                cart_id       <= '0;
                cart_exrom    <= '0;
                cart_game     <= '0;
                cart_attached <= 1'b0;
                crt_error     <= 1'b0;
            end else if (dl_fall) begin
                if (state == StChdr && pcnt == 32'd0 && any_bank) begin
                    cart_attached <= 1'b1;
`ifdef CRT_BIN_EN
                end else if (state == StBin) begin
                    if (cnt <= 32'd16384) begin
                        cart_exrom      <= 8'd0;
                        cart_game       <= (cnt <= 32'd8192) ? 8'd1 : 8'd0;
                        cart_bank_laddr <= 16'h8000;
                        cart_bank_size  <= cnt[15:0];
                        cart_bank_num   <= 16'd0;
                        cart_bank_type  <= 8'd0;
                        cart_bank_raddr <= RAM_BASE;
                        cart_bank_wr    <= 1'b1;
                        cart_attached   <= 1'b1;
                    end else begin
                        crt_error <= 1'b1;
                    end
`endif
                end else if (state != StIdle) begin
                    crt_error <= 1'b1;
                end
                state <= StIdle;
            end else if (dl_wr && state != StIdle && state != StErr) begin
                cnt <= cnt_nx;
                case (state)
                    StSig: begin
`ifdef CRT_BIN_EN
                        if (cnt == 32'd0 && dl_data != 8'h43) begin
                            state    <= StBin;
                            cart_id  <= '0;
                            mem_wr   <= 1'b1;
                            mem_addr <= RAM_BASE;
                            mem_data <= dl_data;
                        end else
`endif
                        if (dl_data != sig_word[127:120]) begin
                            state     <= StErr;
                            crt_error <= 1'b1;
                        end else if (cnt == 32'd15) begin
                            state <= StHdr;
                        end
                    end
                    StHdr: begin
                        case (cnt)
                            32'h10:  hdr_len[31:24]   <= dl_data;
                            32'h11:  hdr_len[23:16]   <= dl_data;
                            32'h12:  hdr_len[15:8]    <= dl_data;
                            32'h13:  hdr_len[7:0]     <= dl_data;
                            32'h16:  cart_id[15:8]    <= dl_data;
                            32'h17:  cart_id[7:0]     <= dl_data;
                            32'h18:  cart_exrom       <= dl_data;
                            32'h19:  cart_game        <= dl_data;
                            default: ;
                        endcase
                        if (cnt_nx == hdr_eff) begin
                            state <= StChdr;
                            pcnt  <= '0;
                        end
                    end
                    StChdr: begin
                        pcnt <= pcnt_nx;
                        case (pcnt[3:0])
                            4'd0, 4'd1, 4'd2, 4'd3: begin
                                if (dl_data != chip_word[31:24]) begin
                                    state     <= StErr;
                                    crt_error <= 1'b1;
                                end
                            end
                            4'd4:  pkt_len[31:24]        <= dl_data;
                            4'd5:  pkt_len[23:16]        <= dl_data;
                            4'd6:  pkt_len[15:8]         <= dl_data;
                            4'd7:  pkt_len[7:0]          <= dl_data;
                            4'd8:  ;                     // type high byte is not used
                            4'd9:  cart_bank_type        <= dl_data;
                            4'd10: cart_bank_num[15:8]   <= dl_data;
                            4'd11: cart_bank_num[7:0]    <= dl_data;
                            4'd12: cart_bank_laddr[15:8] <= dl_data;
                            4'd13: cart_bank_laddr[7:0]  <= dl_data;
                            4'd14: cart_bank_size[15:8]  <= dl_data;
                            4'd15: begin
                                cart_bank_size[7:0] <= dl_data;
                                if (units_over) begin
                                    state     <= StErr;
                                    crt_error <= 1'b1;
                                end else begin
                                    cart_bank_raddr <= RAM_BASE + 25'({unit_ptr, 13'd0});
                                    unit_ptr        <= unit_ptr + {4'd0, units};
                                    cart_bank_wr    <= 1'b1;
                                    any_bank        <= 1'b1;
                                    if (size_now != 16'd0) begin
                                        state <= StCdata;
                                    end else if (pkt_len > 32'd16) begin
                                        state <= StCskip;
                                    end else begin
                                        pcnt <= '0;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                    StCdata: begin
                        mem_wr   <= 1'b1;
                        mem_data <= dl_data;
                        mem_addr <= cart_bank_raddr + data_off[24:0];
                        pcnt     <= pcnt_nx;
                        if (pcnt_nx == data_end) begin
                            // Skip straight to the next header when no padding follows
                            if (pkt_len > pcnt_nx) begin
                                state <= StCskip;
                            end else begin
                                state <= StChdr;
                                pcnt  <= '0;
                            end
                        end
                    end
                    StCskip: begin
                        pcnt <= pcnt_nx;
                        if (pcnt_nx >= pkt_len) begin
                            state <= StChdr;
                            pcnt  <= '0;
                        end
                    end
                    StBin: begin
                        mem_wr   <= 1'b1;
                        mem_data <= dl_data;
                        mem_addr <= RAM_BASE + cnt[24:0];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crt_parser.sv
// Scoreboard bench for crt_parser: builds CRT images, streams them and checks SDRAM writes,
// bank descriptors and final mapper status.
module tb_crt_parser;

    logic        clk32 = 1'b0;
    logic        reset;
    logic        dl_active;
    logic        dl_wr;
    logic [7:0]  dl_data;
    logic [24:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wr;
    logic [15:0] cart_id;
    logic [7:0]  cart_exrom;
    logic [7:0]  cart_game;
    logic [15:0] cart_bank_laddr;
    logic [15:0] cart_bank_size;
    logic [15:0] cart_bank_num;
    logic [7:0]  cart_bank_type;
    logic [24:0] cart_bank_raddr;
    logic        cart_bank_wr;
    logic        cart_loading;
    logic        cart_attached;
    logic        crt_error;

    crt_parser dut (
        .clk32           (clk32),
        .reset           (reset),
        .dl_active       (dl_active),
        .dl_wr           (dl_wr),
        .dl_data         (dl_data),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .mem_wr          (mem_wr),
        .cart_id         (cart_id),
        .cart_exrom      (cart_exrom),
        .cart_game       (cart_game),
        .cart_bank_laddr (cart_bank_laddr),
        .cart_bank_size  (cart_bank_size),
        .cart_bank_num   (cart_bank_num),
        .cart_bank_type  (cart_bank_type),
        .cart_bank_raddr (cart_bank_raddr),
        .cart_bank_wr    (cart_bank_wr),
        .cart_loading    (cart_loading),
        .cart_attached   (cart_attached),
        .crt_error       (crt_error)
    );

    always #5 clk32 = ~clk32;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboards: {addr, data} per payload byte and {raddr, laddr, size, num, type} per bank
    logic [32:0] mem_q[$];
    logic [80:0] bank_q[$];
    logic [32:0] mem_e;
    logic [80:0] bank_e;
    int          mem_seen = 0;
    bit          exp_on = 1'b1;

    // Image under construction; mark holds the expected SDRAM address of payload bytes, else -1
    logic [7:0]  img[$];
    int          mark[$];

    // Output monitor, sampled away from the active edge
    always @(negedge clk32) begin
        if (mem_wr === 1'b1) begin
            mem_seen++;
            if (mem_q.size() == 0) begin
                check("mem_unexpected_depth", 96'(mem_q.size()), 96'd1);
            end else begin
                mem_e = mem_q.pop_front();
                check("mem_write", {mem_addr, mem_data}, mem_e);
            end
        end
        if (cart_bank_wr === 1'b1) begin
            if (bank_q.size() == 0) begin
                check("bank_unexpected_depth", 96'(bank_q.size()), 96'd1);
            end else begin
                bank_e = bank_q.pop_front();
                check("bank_wr", {cart_bank_raddr, cart_bank_laddr, cart_bank_size,
                                  cart_bank_num, cart_bank_type}, bank_e);
            end
        end
    end

    task automatic put(input logic [7:0] b, input int m);
        img.push_back(b);
        mark.push_back(m);
    endtask

    task automatic put_be(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) put(v[8*i +: 8], -1);
    endtask

    task automatic add_hdr(input int hlen, input int id, input int exrom, input int game);
        string s;
        int    total;
        s = "C64 CARTRIDGE   ";
        img.delete();
        mark.delete();
        for (int i = 0; i < 16; i++) put(s[i], -1);
        put_be(32'(hlen), 4);
        put_be(32'h0100, 2);
        put_be(32'(id), 2);
        put(8'(exrom), -1);
        put(8'(game), -1);
        total = (hlen < 64) ? 64 : hlen;
        while (img.size() < total) put(8'h00, -1);
    endtask

    task automatic add_chip(input int plen, input int typ, input int num, input int laddr,
                            input int size, input int raddr, input int seed);
        put_be(32'h43484950, 4);
        put_be(32'(plen), 4);
        put_be(32'(typ), 2);
        put_be(32'(num), 2);
        put_be(32'(laddr), 2);
        put_be(32'(size), 2);
        for (int i = 0; i < size; i++) put(8'(i * 13 + seed), raddr + i);
        for (int i = 0; i < plen - 16 - size; i++) put(8'hEE, -1);
        bank_q.push_back({25'(raddr), 16'(laddr), 16'(size), 16'(num), 8'(typ)});
    endtask

    task automatic stream(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk32);
            dl_wr   = 1'b1;
            dl_data = img[i];
            if (exp_on && mark[i] >= 0) mem_q.push_back({25'(mark[i]), img[i]});
        end
        @(negedge clk32);
        dl_wr = 1'b0;
    endtask

    task automatic start_dl();
        @(negedge clk32);
        dl_active = 1'b1;
        repeat (2) @(negedge clk32);
    endtask

    task automatic end_dl();
        @(negedge clk32);
        dl_active = 1'b0;
        repeat (3) @(negedge clk32);
    endtask

    task automatic check_end(input string tag, input logic att, input logic err);
        check({tag, "_attached"}, cart_attached, att);
        check({tag, "_error"}, crt_error, err);
        check({tag, "_mem_left"}, 96'(mem_q.size()), 96'd0);
        check({tag, "_bank_left"}, 96'(bank_q.size()), 96'd0);
    endtask

    task automatic run_full(input string tag);
        start_dl();
        check({tag, "_loading"}, cart_loading, 1'b1);
        stream(0, img.size());
        end_dl();
    endtask

    int seen0;

    initial begin
        reset     = 1'b1;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_data   = 8'h00;
        repeat (3) @(negedge clk32);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_mem_addr", mem_addr, 25'd0);
        check("rst_bank_wr", cart_bank_wr, 1'b0);
        check("rst_cart_id", cart_id, 16'd0);
        check("rst_loading", cart_loading, 1'b0);
        check("rst_attached", cart_attached, 1'b0);
        check("rst_error", crt_error, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk32);

        // 16K generic cartridge
        add_hdr(64, 0, 0, 0);
        add_chip(32'h4010, 0, 0, 32'h8000, 32'h4000, 32'h0100000, 1);
        mem_seen = 0;
        run_full("gen16k");
        check("gen16k_writes", 96'(mem_seen), 96'd16384);
        check("gen16k_id", cart_id, 16'd0);
        check("gen16k_exrom", cart_exrom, 8'd0);
        check("gen16k_game", cart_game, 8'd0);
        check("gen16k_loading_off", cart_loading, 1'b0);
        check_end("gen16k", 1'b1, 1'b0);

        // EasyFlash: two 8K CHIPs packed on consecutive 8K units
        add_hdr(64, 32, 1, 0);
        add_chip(32'h2010, 2, 0, 32'h8000, 32'h2000, 32'h0100000, 3);
        add_chip(32'h2010, 2, 0, 32'hA000, 32'h2000, 32'h0102000, 5);
        run_full("ef");
        check("ef_id", cart_id, 16'h0020);
        check("ef_exrom", cart_exrom, 8'd1);
        check("ef_game", cart_game, 8'd0);
        check_end("ef", 1'b1, 1'b0);

        // Corrupt signature byte 3
        add_hdr(64, 0, 0, 0);
        img[3] = 8'h58;
        for (int i = 0; i < 32; i++) put(8'(i), -1);
        mem_seen = 0;
        start_dl();
        stream(0, 3);
        check("sig_err_before", crt_error, 1'b0);
        stream(3, 4);
        check("sig_err_at3", crt_error, 1'b1);
        stream(4, img.size());
        end_dl();
        check("sig_no_writes", 96'(mem_seen), 96'd0);
        check_end("sig", 1'b0, 1'b1);

        // Short header length: CHIP still found at 0x40
        add_hdr(32'h20, 0, 0, 1);
        add_chip(32'h110, 0, 0, 32'h8000, 32'h100, 32'h0100000, 7);
        run_full("hdr20");
        check("hdr20_game", cart_game, 8'd1);
        check_end("hdr20", 1'b1, 1'b0);

        // Packet padding skipped, following CHIP accepted
        add_hdr(64, 0, 0, 0);
        add_chip(32'h2014, 0, 0, 32'h8000, 32'h2000, 32'h0100000, 9);
        add_chip(32'h110, 0, 1, 32'hA000, 32'h100, 32'h0102000, 11);
        run_full("skip");
        check_end("skip", 1'b1, 1'b0);

        // Download ends in the middle of a CHIP payload
        add_hdr(64, 0, 0, 0);
        add_chip(32'h2010, 0, 0, 32'h8000, 32'h2000, 32'h0100000, 13);
        start_dl();
        stream(0, 64 + 16 + 100);
        end_dl();
        check_end("trunc", 1'b0, 1'b1);

        // Reset pulse mid-stream, then a clean download
        add_hdr(64, 32'h11, 0, 0);
        add_chip(32'h110, 0, 0, 32'h8000, 32'h100, 32'h0100000, 15);
        start_dl();
        stream(0, 64 + 16 + 40);
        check("rstmid_id_before", cart_id, 16'h0011);
        @(negedge clk32);
        reset = 1'b1;
        @(negedge clk32);
        check("rstmid_mem_wr", mem_wr, 1'b0);
        check("rstmid_loading", cart_loading, 1'b0);
        check("rstmid_id", cart_id, 16'd0);
        check("rstmid_raddr", cart_bank_raddr, 25'd0);
        check("rstmid_error", crt_error, 1'b0);
        reset = 1'b0;
        seen0 = mem_seen;
        exp_on = 1'b0;
        stream(64 + 16 + 40, img.size());
        exp_on = 1'b1;
        end_dl();
        check("rstmid_ignored", 96'(mem_seen - seen0), 96'd0);
        check_end("rstmid", 1'b0, 1'b0);
        add_hdr(64, 32'h11, 0, 0);
        add_chip(32'h110, 0, 0, 32'h8000, 32'h100, 32'h0100000, 17);
        run_full("after_rst");
        check("after_rst_id", cart_id, 16'h0011);
        check_end("after_rst", 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
